// File: rtl/dual_issue_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dual_issue_ctrl_pkg
// Brief    : Opcodes, decoded-instruction layout and op classification helpers
// Revision : 1.0 - initial release
// ============================================================================
package dual_issue_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic [6:0] op;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } decoder_t;

    localparam int INSTR_W = $bits(decoder_t);

    typedef enum logic {PAIR, SPLIT} issue_st_e;

    function automatic logic writes_rd(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_LOAD, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: return 1'b1;
            default:                                                return 1'b0;
        endcase
    endfunction

    function automatic logic reads_rs1(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR: return 1'b1;
            default:                                           return 1'b0;
        endcase
    endfunction

    function automatic logic reads_rs2(input logic [6:0] op);
        case (op)
            OP_R, OP_STORE, OP_BRANCH: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

    function automatic logic is_mem(input logic [6:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

    function automatic logic is_ctl(input logic [6:0] op);
        return (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
    endfunction

    function automatic string issue_st_to_string(input issue_st_e s);
        return (s == SPLIT) ? "SPLIT" : "PAIR";
    endfunction

endpackage
`default_nettype wire

// File: rtl/dual_issue_ctrl_dep_match.sv
`default_nettype none
// ============================================================================
// Module   : dual_issue_ctrl_dep_match
// Brief    : Flags a consumer source register that matches a producer's rd
// Revision : 1.0 - initial release
// ============================================================================
module dual_issue_ctrl_dep_match
    import dual_issue_ctrl_pkg::*;
(
    input  logic [6:0] i_op,
    input  logic [4:0] i_rs1,
    input  logic [4:0] i_rs2,
    input  logic [4:0] i_prod_rd,
    input  logic       i_prod_wr,
    output logic       o_hit
);

    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rs1_hit = reads_rs1(i_op) && (i_rs1 == i_prod_rd);
    assign w_rs2_hit = reads_rs2(i_op) && (i_rs2 == i_prod_rd);
    // x0 is hard-wired zero, so it never carries a dependency
    assign o_hit     = i_prod_wr && (i_prod_rd != 5'd0) && (w_rs1_hit || w_rs2_hit);

endmodule
`default_nettype wire

// File: rtl/dual_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dual_issue_ctrl
// Brief    : Dual-issue scheduler between ID and ID_EX with split/stall control
// Revision : 1.0 - initial release
// ============================================================================
module dual_issue_ctrl
    import dual_issue_ctrl_pkg::*;
#(
    parameter int MEM_PORTS = 1,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic               flush,
    input  logic [INSTR_W-1:0] id_A,
    input  logic [INSTR_W-1:0] id_B,
    input  logic [4:0]         ex_A_rd,
    input  logic               ex_A_load,
    input  logic [4:0]         ex_B_rd,
    input  logic               ex_B_load,
    output logic               issue_A,
    output logic               issue_B,
    output logic               hold_ifid,
    output logic               split_st,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   split_cnt
);

    localparam logic             c_ONE_PORT = (MEM_PORTS == 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};

    decoder_t   w_a;
    decoder_t   w_b;
    logic       w_unused_b_rd;
    logic [6:0] w_op  [2];
    logic [4:0] w_rs1 [2];
    logic [4:0] w_rs2 [2];
    logic [4:0] w_ex_rd [2];
    logic       w_ex_ld [2];
    logic [3:0] w_lu_hit;
    logic       w_lu_a, w_lu_b, w_raw, w_memc, w_ctl;

    issue_st_e        r_state;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_split_cnt;

    issue_st_e w_nxt;
    logic      w_issue_a, w_issue_b, w_hold, w_split_inc, w_stall_inc;

    assign w_a           = id_A;
    assign w_b           = id_B;
    assign w_unused_b_rd = ^w_b.rd;

    assign w_op[0]    = w_a.op;
    assign w_op[1]    = w_b.op;
    assign w_rs1[0]   = w_a.rs1;
    assign w_rs1[1]   = w_b.rs1;
    assign w_rs2[0]   = w_a.rs2;
    assign w_rs2[1]   = w_b.rs2;
    assign w_ex_rd[0] = ex_A_rd;
    assign w_ex_rd[1] = ex_B_rd;
    assign w_ex_ld[0] = ex_A_load;
    assign w_ex_ld[1] = ex_B_load;

    // Load-use: each ID lane against each ID_EX lane holding a load
    for (genvar c = 0; c < 2; c++) begin : g_cons
        for (genvar p = 0; p < 2; p++) begin : g_prod
            dual_issue_ctrl_dep_match u_lu (
                .i_op      (w_op[c]),
                .i_rs1     (w_rs1[c]),
                .i_rs2     (w_rs2[c]),
                .i_prod_rd (w_ex_rd[p]),
                .i_prod_wr (w_ex_ld[p]),
                .o_hit     (w_lu_hit[c*2+p])
            );
        end
    end

    dual_issue_ctrl_dep_match u_raw (
        .i_op      (w_b.op),
        .i_rs1     (w_b.rs1),
        .i_rs2     (w_b.rs2),
        .i_prod_rd (w_a.rd),
        .i_prod_wr (writes_rd(w_a.op)),
        .o_hit     (w_raw)
    );

    assign w_lu_a = |w_lu_hit[1:0];
    assign w_lu_b = |w_lu_hit[3:2];
    assign w_memc = c_ONE_PORT && is_mem(w_a.op) && is_mem(w_b.op);
    assign w_ctl  = is_ctl(w_a.op);

    always_comb begin
        w_issue_a   = 1'b0;
        w_issue_b   = 1'b0;
        w_hold      = 1'b0;
        w_split_inc = 1'b0;
        w_nxt       = r_state;
        // IF/ID is frozen in SPLIT, so losing id_valid there is a squash
        if (rst || flush || (r_state == SPLIT && !id_valid)) begin
            w_nxt = PAIR;
        end else if (r_state == PAIR) begin
            if (id_valid) begin
                if (w_lu_a) begin
                    w_hold = 1'b1;
                end else if (w_raw || w_memc || w_ctl || w_lu_b) begin
                    w_issue_a   = 1'b1;
                    w_hold      = 1'b1;
                    w_split_inc = 1'b1;
                    w_nxt       = SPLIT;
                end else begin
                    w_issue_a = 1'b1;
                    w_issue_b = 1'b1;
                end
            end
        end else begin
            if (w_lu_b) begin
                w_hold = 1'b1;
            end else begin
                w_issue_b = 1'b1;
                w_nxt     = PAIR;
            end
        end
    end

    assign w_stall_inc = w_hold && !w_issue_a && !w_issue_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= PAIR;
            r_stall_cnt <= '0;
            r_split_cnt <= '0;
        end else begin
            r_state <= w_nxt;
            if (w_stall_inc && (r_stall_cnt != c_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
            end
            if (w_split_inc && (r_split_cnt != c_CNT_MAX)) begin
                r_split_cnt <= r_split_cnt + c_CNT_ONE;
            end
        end
    end

    assign issue_A   = w_issue_a;
    assign issue_B   = w_issue_b;
    assign hold_ifid = w_hold;
    assign split_st  = !rst && (r_state == SPLIT);
    assign stall_cnt = r_stall_cnt;
    assign split_cnt = r_split_cnt;

endmodule
`default_nettype wire
